// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the command executor: command codes, FSM encoding
// and the register-file slots that receive the ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE, RD_ADDR, RD_WAIT, OPA, OPA_WR, OPB, OPB_WR,
    FUN, ALU_WAIT, PUSH_LO, PUSH_HI, PUSH_RD
  } state_e;

  function automatic logic is_push(state_e s);
    return (s == PUSH_LO) || (s == PUSH_HI) || (s == PUSH_RD);
  endfunction

endpackage

// File: rtl/rsp_timer.sv
// Response wait counter: counts enabled cycles and flags the last allowed one.
module rsp_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cmd_exec_ctrl.sv
// UART command executor: decodes RF-read and ALU command frames, drives the
// register file / ALU, and pushes responses into the TX FIFO.
module cmd_exec_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_FUN_WIDTH = 4,
  parameter int RSP_TIMEOUT   = 16
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [DATA_WIDTH-1:0]    i_RX_P_DATA,
  input  logic                     i_RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    i_RdData,
  input  logic                     i_RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0]  i_ALU_OUT,
  input  logic                     i_OUT_Valid,
  input  logic                     i_FIFO_FULL,
  output logic [ADDR_WIDTH-1:0]    o_Address,
  output logic                     o_RdEn,
  output logic                     o_WrEn,
  output logic [DATA_WIDTH-1:0]    o_WrData,
  output logic [ALU_FUN_WIDTH-1:0] o_ALU_FUN,
  output logic                     o_ALU_EN,
  output logic                     o_CLK_EN,
  output logic [DATA_WIDTH-1:0]    o_FIFO_DATA,
  output logic                     o_WR_INC,
  output logic                     o_busy,
  output logic                     o_err
);
  localparam logic [DATA_WIDTH-1:0] CODE_RD      = DATA_WIDTH'(CMD_RD);
  localparam logic [DATA_WIDTH-1:0] CODE_ALU_OP  = DATA_WIDTH'(CMD_ALU_OP);
  localparam logic [DATA_WIDTH-1:0] CODE_ALU_NOP = DATA_WIDTH'(CMD_ALU_NOP);

  state_e                   state;
  logic [ADDR_WIDTH-1:0]    addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic [DATA_WIDTH-1:0]    rdata;
  logic [ALU_FUN_WIDTH-1:0] fun;
  logic [2*DATA_WIDTH-1:0]  result;
  logic                     err;
  logic                     wait_st;
  logic                     rsp_vld;
  logic                     expired;
  logic                     tmr_clr;

  assign wait_st = (state == RD_WAIT) || (state == ALU_WAIT);
  assign rsp_vld = ((state == RD_WAIT) && i_RdData_Valid) ||
                   ((state == ALU_WAIT) && i_OUT_Valid);
  // Clearing on the leaving edge as well keeps the count at zero on every entry.
  assign tmr_clr = !wait_st || rsp_vld || expired;

  rsp_timer #(.TIMEOUT(RSP_TIMEOUT)) u_timer (
    .clk     (i_CLK),
    .rst     (i_RST),
    .clear   (tmr_clr),
    .enable  (wait_st),
    .expired (expired)
  );

  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      state  <= IDLE;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      fun    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (i_RX_D_VLD) begin
          if (i_RX_P_DATA == CODE_RD)           state <= RD_ADDR;
          else if (i_RX_P_DATA == CODE_ALU_OP)  state <= OPA;
          else if (i_RX_P_DATA == CODE_ALU_NOP) state <= FUN;
        end
        RD_ADDR: if (i_RX_D_VLD) begin
          addr  <= i_RX_P_DATA[ADDR_WIDTH-1:0];
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          // A valid arriving on the last allowed cycle beats the timeout.
          if (i_RdData_Valid) begin
            rdata <= i_RdData;
            state <= PUSH_RD;
          end else if (expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        OPA: if (i_RX_D_VLD) begin
          wdata <= i_RX_P_DATA;
          state <= OPA_WR;
        end
        OPA_WR: state <= OPB;
        OPB: if (i_RX_D_VLD) begin
          wdata <= i_RX_P_DATA;
          state <= OPB_WR;
        end
        OPB_WR: state <= FUN;
        FUN: if (i_RX_D_VLD) begin
          fun   <= i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
          state <= ALU_WAIT;
        end
        ALU_WAIT: begin
          if (i_OUT_Valid) begin
            result <= i_ALU_OUT;
            state  <= PUSH_LO;
          end else if (expired) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        PUSH_LO: if (!i_FIFO_FULL) state <= PUSH_HI;
        PUSH_HI: if (!i_FIFO_FULL) state <= IDLE;
        PUSH_RD: if (!i_FIFO_FULL) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_Address   = '0;
    o_RdEn      = 1'b0;
    o_WrEn      = 1'b0;
    o_WrData    = '0;
    o_ALU_FUN   = '0;
    o_ALU_EN    = 1'b0;
    o_CLK_EN    = 1'b0;
    o_FIFO_DATA = '0;
    case (state)
      RD_WAIT: begin
        o_RdEn    = 1'b1;
        o_Address = addr;
      end
      OPA_WR: begin
        o_WrEn    = 1'b1;
        o_Address = ADDR_WIDTH'(OPA_ADDR);
        o_WrData  = wdata;
      end
      OPB_WR: begin
        o_WrEn    = 1'b1;
        o_Address = ADDR_WIDTH'(OPB_ADDR);
        o_WrData  = wdata;
      end
      ALU_WAIT: begin
        o_ALU_EN  = 1'b1;
        o_CLK_EN  = 1'b1;
        o_ALU_FUN = fun;
      end
      PUSH_LO: o_FIFO_DATA = result[DATA_WIDTH-1:0];
      PUSH_HI: o_FIFO_DATA = result[2*DATA_WIDTH-1:DATA_WIDTH];
      PUSH_RD: o_FIFO_DATA = rdata;
      default: ;
    endcase
  end

  // Push strobe is withheld while the FIFO is full; data stays on the bus.
  assign o_WR_INC = is_push(state) && !i_FIFO_FULL;
  assign o_busy   = (state != IDLE);
  assign o_err    = err;

endmodule

// File: tb/tb_cmd_exec_ctrl.sv
// Bench for cmd_exec_ctrl: a procedural command-level model predicts outputs
// every cycle; directed frames plus literal checks on the observed pushes.
module tb_cmd_exec_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic [15:0] alu_out;
  logic        out_vld;
  logic        full;
  logic [3:0]  o_Address;
  logic        o_RdEn, o_WrEn, o_ALU_EN, o_CLK_EN, o_WR_INC, o_busy, o_err;
  logic [7:0]  o_WrData, o_FIFO_DATA;
  logic [3:0]  o_ALU_FUN;

  cmd_exec_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .RSP_TIMEOUT(TO)) dut (
    .i_CLK(clk), .i_RST(rst), .i_RX_P_DATA(rx_data), .i_RX_D_VLD(rx_vld),
    .i_RdData(rd_data), .i_RdData_Valid(rd_vld), .i_ALU_OUT(alu_out),
    .i_OUT_Valid(out_vld), .i_FIFO_FULL(full), .o_Address(o_Address),
    .o_RdEn(o_RdEn), .o_WrEn(o_WrEn), .o_WrData(o_WrData), .o_ALU_FUN(o_ALU_FUN),
    .o_ALU_EN(o_ALU_EN), .o_CLK_EN(o_CLK_EN), .o_FIFO_DATA(o_FIFO_DATA),
    .o_WR_INC(o_WR_INC), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;
  bit chk_en = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: expected outputs for the current cycle
  logic       e_busy, e_rden, e_wren, e_alu, e_push, e_err;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wdata, e_fdata;
  bit         err_next;

  task automatic clr_exp();
    e_busy = 0; e_rden = 0; e_wren = 0; e_alu = 0; e_push = 0; e_err = 0;
    e_addr = 0; e_fun = 0; e_wdata = 0; e_fdata = 0;
  endtask

  task automatic tick(output bit ab);
    @(posedge clk);
    ab = !rst;
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ab);
    do begin tick(ab); end while (!ab && !rx_vld);
    b = rx_data;
  endtask

  task automatic wait_rsp(input bit alu, output logic [15:0] v, output bit ab, output bit tmo);
    tmo = 0; v = 0; ab = 0;
    for (int n = 0; n < TO; n++) begin
      tick(ab);
      if (ab) return;
      if (alu ? out_vld : rd_vld) begin
        v = alu ? alu_out : {8'h00, rd_data};
        return;
      end
    end
    tmo = 1;
  endtask

  task automatic push(input logic [7:0] d, output bit ab);
    clr_exp(); e_busy = 1; e_push = 1; e_fdata = d;
    do begin tick(ab); end while (!ab && full);
  endtask

  task automatic do_read();
    bit ab, tmo; logic [7:0] b; logic [15:0] v;
    clr_exp(); e_busy = 1;
    get_byte(b, ab); if (ab) return;
    clr_exp(); e_busy = 1; e_rden = 1; e_addr = b[3:0];
    wait_rsp(0, v, ab, tmo); if (ab) return;
    if (tmo) begin err_next = 1; return; end
    push(v[7:0], ab);
  endtask

  task automatic do_alu(input bit ops);
    bit ab, tmo; logic [7:0] b; logic [15:0] v;
    if (ops) begin
      for (int k = 0; k < 2; k++) begin
        clr_exp(); e_busy = 1;
        get_byte(b, ab); if (ab) return;
        clr_exp(); e_busy = 1; e_wren = 1; e_addr = 4'(k); e_wdata = b;
        tick(ab); if (ab) return;
      end
    end
    clr_exp(); e_busy = 1;
    get_byte(b, ab); if (ab) return;
    clr_exp(); e_busy = 1; e_alu = 1; e_fun = b[3:0];
    wait_rsp(1, v, ab, tmo); if (ab) return;
    if (tmo) begin err_next = 1; return; end
    push(v[7:0], ab); if (ab) return;
    push(v[15:8], ab);
  endtask

  initial begin : model
    bit ab;
    err_next = 0;
    forever begin
      clr_exp(); e_err = err_next; err_next = 0;
      tick(ab);
      if (!ab && rx_vld) begin
        if (rx_data == 8'hBB)      do_read();
        else if (rx_data == 8'hCC) do_alu(1);
        else if (rx_data == 8'hDD) do_alu(0);
      end
    end
  end

  // ---------------- compare + observation log
  logic [7:0] pushq[$];
  int         push_cyc[$];
  logic [3:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         err_cnt, err_cyc, rden_cnt;
  logic [3:0] rden_addr;

  always @(negedge clk) if (chk_en) begin
    chk("busy",   32'(o_busy),   32'(e_busy));
    chk("rden",   32'(o_RdEn),   32'(e_rden));
    chk("wren",   32'(o_WrEn),   32'(e_wren));
    chk("alu_en", 32'(o_ALU_EN), 32'(e_alu));
    chk("clk_en", 32'(o_CLK_EN), 32'(e_alu));
    chk("wr_inc", 32'(o_WR_INC), 32'(e_push && !full));
    chk("err",    32'(o_err),    32'(e_err));
    if (e_rden || e_wren) chk("addr", 32'(o_Address), 32'(e_addr));
    if (e_wren) chk("wrdata", 32'(o_WrData), 32'(e_wdata));
    if (e_alu)  chk("alu_fun", 32'(o_ALU_FUN), 32'(e_fun));
    if (e_push) chk("fifo_data", 32'(o_FIFO_DATA), 32'(e_fdata));
    if (o_WR_INC === 1'b1) begin pushq.push_back(o_FIFO_DATA); push_cyc.push_back(cyc_n); end
    if (o_WrEn === 1'b1) begin wr_a.push_back(o_Address); wr_d.push_back(o_WrData); end
    if (o_err === 1'b1) begin err_cnt++; err_cyc = cyc_n; end
    if (o_RdEn === 1'b1) begin rden_cnt++; rden_addr = o_Address; end
  end

  function automatic logic [7:0] pq(input int i);
    return (i < pushq.size()) ? pushq[i] : 8'hxx;
  endfunction

  // ---------------- stimulus
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic send(input logic [7:0] b);
    rx_data = b; rx_vld = 1; cyc(); rx_vld = 0;
  endtask
  task automatic clear_logs();
    pushq.delete(); push_cyc.delete(); wr_a.delete(); wr_d.delete();
    err_cnt = 0; err_cyc = 0; rden_cnt = 0; rden_addr = 0;
  endtask
  task automatic chk_all_zero(input string nm);
    chk(nm, 32'({o_Address, o_RdEn, o_WrEn, o_WrData, o_ALU_FUN, o_ALU_EN, o_CLK_EN,
                 o_FIFO_DATA, o_WR_INC, o_busy, o_err}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, cap, k;
    rst = 0; rx_vld = 0; rx_data = 0; rd_vld = 0; rd_data = 0;
    out_vld = 0; alu_out = 0; full = 0;
    clear_logs();
    cyc(); cyc();
    chk_en = 1;
    chk_all_zero("reset_outputs");
    rst = 1; cyc();

    // RF read of address 5, data valid on the third wait cycle
    clear_logs();
    send(8'hBB); send(8'h05); cyc(); cyc();
    rd_data = 8'h3C; rd_vld = 1; cyc(); rd_vld = 0; rd_data = 0;
    cyc(); cyc();
    chk("rd_push_count", 32'(pushq.size()), 32'd1);
    chk("rd_push_byte", 32'(pq(0)), 32'h3C);
    chk("rd_rden_cycles", 32'(rden_cnt), 32'd3);
    chk("rd_rden_addr", 32'(rden_addr), 32'd5);

    // ALU with operands; long idle in OPA, junk byte during OPA_WR is dropped
    clear_logs();
    send(8'hCC); repeat (20) cyc();
    send(8'h12); send(8'h99); send(8'h34); cyc(); send(8'h00);
    alu_out = 16'h0046; out_vld = 1; cyc(); out_vld = 0; cap = cyc_n;
    cyc(); cyc(); cyc();
    chk("op_wr_count", 32'(wr_a.size()), 32'd2);
    chk("op_wr0", 32'({wr_a.size() > 0 ? wr_a[0] : 4'hx, wr_d.size() > 0 ? wr_d[0] : 8'hxx}), 32'h012);
    chk("op_wr1", 32'({wr_a.size() > 1 ? wr_a[1] : 4'hx, wr_d.size() > 1 ? wr_d[1] : 8'hxx}), 32'h134);
    chk("op_push_count", 32'(pushq.size()), 32'd2);
    chk("op_push_lo", 32'(pq(0)), 32'h46);
    chk("op_push_hi", 32'(pq(1)), 32'h00);
    if (push_cyc.size() == 2) begin
      chk("op_lo_latency", 32'(push_cyc[0] - cap), 32'd0);
      chk("op_hi_next", 32'(push_cyc[1] - push_cyc[0]), 32'd1);
    end

    // ALU without operands; FIFO full for 3 cycles around the result
    clear_logs();
    send(8'hDD); send(8'h02);
    alu_out = 16'hABCD; out_vld = 1; full = 1; cyc(); out_vld = 0;
    cyc(); cyc(); full = 0;
    cyc(); cyc(); cyc();
    chk("nop_push_count", 32'(pushq.size()), 32'd2);
    chk("nop_push_lo", 32'(pq(0)), 32'hCD);
    chk("nop_push_hi", 32'(pq(1)), 32'hAB);
    chk("nop_no_wren", 32'(wr_a.size()), 32'd0);

    // Read timeout
    clear_logs();
    send(8'hBB); send(8'h01); t0 = cyc_n;
    k = 0;
    while (err_cnt == 0 && k < 40) begin cyc(); k++; end
    cyc(); cyc();
    chk("tmo_pulses", 32'(err_cnt), 32'd1);
    chk("tmo_delay", 32'(err_cyc - t0), 32'(TO));
    chk("tmo_no_push", 32'(pushq.size()), 32'd0);
    chk("tmo_idle", 32'(o_busy), 32'd0);

    // Valid on the final allowed wait cycle wins over the timeout
    clear_logs();
    send(8'hBB); send(8'h02); repeat (TO - 1) cyc();
    rd_data = 8'h5A; rd_vld = 1; cyc(); rd_vld = 0;
    cyc(); cyc();
    chk("edge_no_err", 32'(err_cnt), 32'd0);
    chk("edge_push", 32'(pq(0)), 32'h5A);
    chk("edge_rden_cycles", 32'(rden_cnt), 32'(TO));

    // Reset during PUSH_HI, then junk byte in IDLE
    clear_logs();
    send(8'hDD); send(8'h03);
    alu_out = 16'h1234; out_vld = 1; cyc(); out_vld = 0;
    cyc();
    full = 1; rst = 0; cyc();
    chk_all_zero("mid_reset_outputs");
    full = 0; cyc(); rst = 1;
    send(8'h77);
    repeat (3) begin chk("junk_busy", 32'(o_busy), 32'd0); cyc(); end
    chk("rst_push_count", 32'(pushq.size()), 32'd1);
    chk("rst_push_lo", 32'(pq(0)), 32'h34);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
